// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        ZERO = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // Decoder raises start and stalls the pipeline on this ALU op.
    localparam logic [4:0] ALU_DIV  = 5'b10101;
    localparam int         DIV_ITER = 32;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] dvd_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] dvd_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_in[W-1]};
        trial   = shifted - {1'b0, dvs};
        // A carried-out top bit means shifted >= 2^W > dvs, so the trial always fits.
        q_bit   = shifted[W] | ~trial[W];
        rem_out = q_bit ? trial[W-1:0] : shifted[W-1:0];
        dvd_out = {dvd_in[W-2:0], 1'b0};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for MIPS div/divu; quotient to lo, remainder to hi.
// Latency: done 33 cycles after accept (2 for a zero divisor); one quotient bit per cycle.
// Backpressure: start accepted only in IDLE or DONE; ignored (not queued) while busy.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  unsigned_op,
    input  logic [DATA_WIDTH-1:0] OP_A,
    input  logic [DATA_WIDTH-1:0] OP_B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIV_ITER - 1);

    div_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  neg_q, neg_r;
    logic [DATA_WIDTH-1:0] rem_r, dvd_r, dvs_r;
    logic [DATA_WIDTH-1:0] rem_nxt, dvd_nxt, q_word;
    logic                  q_bit;
    logic                  accept, b_zero, a_neg, b_neg;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;

    assign accept = start && (state == IDLE || state == DONE);
    assign b_zero = (OP_B == '0);
    assign a_neg  = !unsigned_op && OP_A[DATA_WIDTH-1];
    assign b_neg  = !unsigned_op && OP_B[DATA_WIDTH-1];
    // Magnitude of the most negative value wraps back to itself, which is the right unsigned value.
    assign abs_a  = a_neg ? -OP_A : OP_A;
    assign abs_b  = b_neg ? -OP_B : OP_B;

    assign busy = (state == RUN) || (state == ZERO);
    assign done = (state == DONE);

    div_step #(.W(DATA_WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_in  (dvd_r),
        .dvs     (dvs_r),
        .rem_out (rem_nxt),
        .dvd_out (dvd_nxt),
        .q_bit   (q_bit)
    );

    // Quotient bits accumulate in the low end of the dividend register as it shifts out.
    assign q_word = dvd_nxt | DATA_WIDTH'(q_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)              state_nxt = b_zero ? ZERO : RUN;
                else if (state == DONE)  state_nxt = IDLE;
            end
            RUN:     if (cnt == LAST_CNT) state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            rem_r       <= '0;
            // Zero-divisor path reports the raw dividend as the remainder.
            dvd_r       <= b_zero ? OP_A : abs_a;
            dvs_r       <= abs_b;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            cnt   <= cnt + CNT_WIDTH'(1);
            rem_r <= rem_nxt;
            dvd_r <= q_word;
            if (cnt == LAST_CNT) begin
                quotient  <= neg_q ? -q_word  : q_word;
                remainder <= neg_r ? -rem_nxt : rem_nxt;
            end
        end else if (state == ZERO) begin
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded random and directed bench for div_unit.
// Latency: checks done timing against accept edge.
// Backpressure: exercises ignored starts and back-to-back starts in DONE.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        unsigned_op = 1'b0;
    logic [31:0] OP_A = '0;
    logic [31:0] OP_B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .unsigned_op (unsigned_op),
        .OP_A        (OP_A),
        .OP_B        (OP_B),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MIPS semantics via plain wide arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic uns);
        exp_t   m;
        longint sa, sb_, lq, lr;
        m.cyc = 0;
        if (b == 32'd0) begin
            m.q = 32'hFFFF_FFFF; m.r = a; m.dbz = 1'b1;
        end else if (uns) begin
            m.q = a / b; m.r = a % b; m.dbz = 1'b0;
        end else begin
            sa = $signed(a); sb_ = $signed(b);
            lq = sa / sb_; lr = sa % sb_;
            m.q = lq[31:0]; m.r = lr[31:0]; m.dbz = 1'b0;
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic uns,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input bit now);
        exp_t e;
        if (!now) @(negedge clk);
        OP_A = a; OP_B = b; unsigned_op = uns; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q = eq; e.r = er; e.dbz = edbz;
        e.cyc = cyc + ((b == 32'd0) ? 1 : 32);
        sb.push_back(e);
        chk("busy_on_accept", busy, 32'd1);
        chk("done_low_on_accept", done, 32'd0);
        chk("dbz_cleared_on_accept", div_by_zero, 32'd0);
    endtask

    task automatic launch_model(input logic [31:0] a, input logic [31:0] b, input logic uns, input bit now);
        exp_t m;
        m = model(a, b, uns);
        launch(a, b, uns, m.q, m.r, m.dbz, now);
    endtask

    // Returns at the negedge where done is visible.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        uns;
        int          saved;

        #12;
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", div_by_zero, 32'd0);
        @(negedge clk) rst = 1'b1;

        launch(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);
        wait_done();
        launch(32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done();
        launch(32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        wait_done();
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        wait_done();
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        wait_done();
        launch(32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_quotient", quotient, 32'hFFFF_FFFF);
        chk("hold_dbz", div_by_zero, 32'd1);
        chk("idle_busy", busy, 32'd0);

        // Start during RUN with different operands must be ignored.
        launch(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0);
        chk("quotient_held_at_accept", quotient, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        OP_A = 32'd9; OP_B = 32'd3; start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_during_run", busy, 32'd1);
        wait_done();
        launch(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_done();

        // Asynchronous reset mid-RUN.
        launch(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_done", done, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_dbz", div_by_zero, 32'd0);
        sb.delete();
        saved = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", done_cnt, saved);
        chk("idle_after_reset", busy, 32'd0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 15);
                4:       b = 32'hFFFF_FFFF;
                5:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            uns = 1'($urandom_range(0, 1));
            launch_model(a, b, uns, (i > 0) && ($urandom_range(0, 1) == 1));
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
